alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one 32-bit combinational ALU instance between NREQ requesters, e.g. the integer pipe and an address-generation or debug port.
- Accepts operation requests over valid/ready handshakes and arbitrates round-robin.
- Drives the ALU from registered operands and returns a registered result, zero flag and error flag, tagged with the requester id.
- Sits between the requesters and the ALU; the ALU's own ports connect only to this block.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width.
- IDW, $clog2(NREQ), requester id width (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_ctrl  in  NREQ*3  packed per-requester ALU op code.
- req_a  in  NREQ*W  packed per-requester operand A.
- req_b  in  NREQ*W  packed per-requester operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  W  ALU result.
- rsp_zero  out  1  ALU zero flag.
- rsp_err  out  1  op code was not a defined operation.
- alu_ctrl  out  3  to ALU Ctrl.
- alu_srca  out  W  to ALU SrcA.
- alu_srcb  out  W  to ALU SrcB.
- alu_result  in  W  from ALU Result.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Op codes: ADD=000, SUB=001, AND=010, OR=011, SLT=101. Codes 100, 110 and 111 are invalid; the ALU returns 32'hDEADBEEF for them and rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is the one-hot round-robin grant among asserted req_valid bits; zero if none is asserted.
  - On a grant (transfer = valid & ready), capture ctrl/a/b/id into operand registers, update the pointer to (granted+1) mod NREQ, and go to EXEC.
- EXEC:
  - req_ready=0.
  - The ALU sees the registered operands.
  - At the clock edge, capture alu_result, alu_zero and err=(ctrl∈{100,110,111}) into response registers; go to RESP.
- RESP:
  - rsp_valid=1 with stable id/data/zero/err until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new grant in the same cycle as the response handshake.
- Latency: request accepted at edge N, rsp_valid high from cycle N+2. Best-case throughput is one op per 3 cycles.
- alu_ctrl/srca/srcb always reflect the operand registers, in every state.
- Round-robin: search starts at the pointer index and wraps NREQ-1→0. Fairness: a continuously asserting requester is granted within NREQ grants.
- Requesters must hold valid and payload until ready. The block does not depend on that; a valid dropped before grant is simply not served.
- Backpressure: rsp_ready low holds RESP indefinitely; all response outputs are stable while held.
- Reset (async, any state, including mid-EXEC or mid-RESP):
  - State goes to IDLE and the pointer to 0.
  - Operand registers clear to 0, so alu_ctrl=000 and alu_srca=alu_srcb=0.
  - Response registers clear: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - req_ready=0 while rst_n=0.
  - The in-flight op is discarded and never responded to.
- Width: no arithmetic is performed here. The SLT result is whatever the ALU returns (unsigned compare, 0/1); it is passed through unchanged.

Decomposition:
- Package alu_pkg holds:
  - the alu_op_e enum (ADD, SUB, AND, OR, SLT, 3-bit);
  - the ALU_ERR_VAL=32'hDEADBEEF constant;
  - the is_valid_op() function;
  - the ctrl_state_e enum (IDLE, EXEC, RESP).
- One natural sub-module: rr_arbiter (parameter NREQ; inputs req, ptr, en; outputs a one-hot grant and a binary index). Reusable by later shared-resource controllers.

Test Plan:
- Reset then single op:
  - Stimulus: req0 ADD a=5 b=7; rsp_ready=1.
  - Response: ready[0] one cycle; rsp_valid two cycles later with id=0, data=12, zero=0, err=0.
- SUB to zero:
  - Stimulus: req1 SUB a=32'h10 b=32'h10.
  - Response: data=0, zero=1, id=1.
- Round-robin contention:
  - Stimulus: both requesters valid continuously, NREQ=2.
  - Response: grants alternate 0,1,0,1; each response id matches its grant order; no starvation over 8 ops.
- Invalid op:
  - Stimulus: req0 ctrl=3'b111, a=1, b=2.
  - Response: data=32'hDEADBEEF, err=1, zero=0.
- Backpressure:
  - Stimulus: SLT a=3 b=9 with rsp_ready=0 for 5 cycles.
  - Response: rsp_valid and data=1 stay stable throughout; req_ready=0 throughout; after rsp_ready=1, IDLE is reached and the next grant happens the following cycle.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during EXEC with AND a=F0 b=FF.
  - Response: immediately rsp_valid=0 and alu_ctrl=0; after release, no stale response appears; a fresh request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU controller: ALU op codes, the value the ALU
// returns for undefined ops, the op-validity check and the controller states.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 3;
  localparam logic [31:0] ALU_ERR_VAL = 32'hDEADBEEF;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // True for op codes the ALU defines; 100, 110 and 111 are not.
  function automatic logic is_valid_op(input logic [ALU_CTRL_W-1:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted req at or after ptr, wrapping.
// Ports: req (requests), ptr (search start index), en (gate; grant is zero
// when low), gnt (one-hot grant, combinational), idx (binary index of gnt).
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int unsigned     pos;
  logic [IDW-1:0]  pos_idx;
  logic            found;

  // Scan NREQ positions starting at ptr; first hit wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos     = (32'(ptr) + i) % NREQ;
      pos_idx = IDW'(pos);
      if (en && !found && req[pos_idx]) begin
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NREQ requesters. Round-robin grant in
// IDLE, one cycle of ALU evaluation in EXEC, registered response held in RESP.
// Ports: req_valid/req_ready/req_ctrl/req_a/req_b (packed per-requester
// request side), rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_zero/rsp_err
// (response side), alu_ctrl/alu_srca/alu_srcb/alu_result/alu_zero (ALU side).
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 32,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*3-1:0] req_ctrl,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [2:0]        alu_ctrl,
  output logic [W-1:0]      alu_srca,
  output logic [W-1:0]      alu_srcb,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero
);

  ctrl_state_e    state, state_d;
  logic [IDW-1:0] ptr;
  logic [2:0]     op_ctrl;
  logic [W-1:0]   op_a, op_b;
  logic [IDW-1:0] op_id;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            arb_en;
  logic            load_op;
  logic            load_rsp;
  logic [2:0]      sel_ctrl;
  logic [W-1:0]    sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // One-hot mux of the granted requester's payload.
  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_ctrl = sel_ctrl | req_ctrl[i*3 +: 3];
        sel_a    = sel_a    | req_a[i*W +: W];
        sel_b    = sel_b    | req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and handshake outputs. Grant is masked by rst_n so req_ready
  // stays low for the whole reset assertion.
  always_comb begin
    state_d   = state;
    arb_en    = 1'b0;
    req_ready = '0;
    load_op   = 1'b0;
    load_rsp  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        arb_en    = rst_n;
        req_ready = gnt;
        if (|gnt) begin
          load_op = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        load_rsp = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      op_ctrl <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= '0;
    end else if (load_op) begin
      ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      op_ctrl <= sel_ctrl;
      op_a    <= sel_a;
      op_b    <= sel_b;
      op_id   <= gnt_idx;
    end
  end

  // Response registers, captured from the ALU at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (load_rsp) begin
      rsp_id   <= op_id;
      rsp_data <= alu_result;
      rsp_zero <= alu_zero;
      rsp_err  <= !is_valid_op(op_ctrl);
    end
  end

  assign alu_ctrl = op_ctrl;
  assign alu_srca = op_a;
  assign alu_srcb = op_b;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 32;
  localparam int unsigned IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_ctrl;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_zero, rsp_err;
  logic [2:0]        alu_ctrl;
  logic [W-1:0]      alu_srca, alu_srcb, alu_result;
  logic              alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural ALU attached to the controller's ALU port.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca - alu_srcb;
      3'b010:  alu_result = alu_srca & alu_srcb;
      3'b011:  alu_result = alu_srca | alu_srcb;
      3'b101:  alu_result = (alu_srca < alu_srcb) ? 32'd1 : 32'd0;
      default: alu_result = ALU_ERR_VAL;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_ctrl[r*3 +: 3] = c;
    req_a[r*W +: W]    = a;
    req_b[r*W +: W]    = b;
    req_valid[r]       = 1'b1;
  endtask

  // Single op with rsp_ready high: grant, EXEC, RESP, back to IDLE.
  task automatic do_op(input string tag, input int r, input logic [2:0] c,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic ez, input logic ee);
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[r] = 1'b1;
    set_req(r, c, a, b);
    #1;
    check({tag, "_ready"}, W'(req_ready), W'(exp_rdy));
    tick();
    req_valid = '0;
    #1;
    check({tag, "_exec_ready"}, W'(req_ready), 32'd0);
    check({tag, "_exec_valid"}, W'(rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, W'(rsp_valid), 32'd1);
    check({tag, "_id"},    W'(rsp_id),    W'(r));
    check({tag, "_data"},  rsp_data,      ed);
    check({tag, "_zero"},  W'(rsp_zero),  W'(ez));
    check({tag, "_err"},   W'(rsp_err),   W'(ee));
    tick();
    check({tag, "_done"},  W'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_ctrl  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_valid", W'(rsp_valid), 32'd0);
    check("rst_ready", W'(req_ready), 32'd0);
    check("rst_ctrl",  W'(alu_ctrl),  32'd0);
    check("rst_srca",  alu_srca,      32'd0);
    check("rst_data",  rsp_data,      32'd0);
    rst_n = 1'b1;
    tick();

    do_op("add", 0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    do_op("sub0", 1, 3'b001, 32'h10, 32'h10, 32'd0, 1'b1, 1'b0);

    // Contention: both valid throughout, pointer is 0, grants alternate.
    set_req(0, 3'b000, 32'd100, 32'd200);
    set_req(1, 3'b011, 32'hF0, 32'h0F);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), W'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      check($sformatf("rr_id%0d", k), W'(rsp_id), W'(k % 2));
      check($sformatf("rr_data%0d", k), rsp_data, (k % 2 == 0) ? 32'd300 : 32'hFF);
      tick();
    end
    req_valid = '0;

    do_op("inv", 0, 3'b111, 32'd1, 32'd2, 32'hDEADBEEF, 1'b0, 1'b1);

    // Backpressure with requester 0 pending behind it.
    rsp_ready = 1'b0;
    set_req(1, 3'b101, 32'd3, 32'd9);
    tick();
    req_valid = '0;
    set_req(0, 3'b000, 32'd1, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), W'(rsp_valid), 32'd1);
      check($sformatf("bp_data%0d", k),  rsp_data,      32'd1);
      check($sformatf("bp_id%0d", k),    W'(rsp_id),    32'd1);
      check($sformatf("bp_ready%0d", k), W'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready", W'(req_ready), 32'd0);
    tick();
    check("bp_idle_valid", W'(rsp_valid), 32'd0);
    check("bp_next_gnt",   W'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_data", rsp_data, 32'd2);
    check("bp_next_id",   W'(rsp_id), 32'd0);
    tick();

    // Reset while EXEC: in-flight op is discarded.
    set_req(0, 3'b010, 32'hF0, 32'hFF);
    tick();
    check("mid_exec_ctrl", W'(alu_ctrl), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(rsp_valid), 32'd0);
    check("mid_rst_ctrl",  W'(alu_ctrl),  32'd0);
    check("mid_rst_srca",  alu_srca,      32'd0);
    check("mid_rst_ready", W'(req_ready), 32'd0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst_valid%0d", k), W'(rsp_valid), 32'd0);
    end
    do_op("fresh", 1, 3'b001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
